// File: rtl/sparce_skip_ctrl_pkg.sv
// Shared SparCE definitions: skip-controller state encoding and instruction size.
package sparce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REDIRECT
    } sparce_skip_state_t;

    localparam int unsigned SPARCE_INST_BYTES = 4;

endpackage

// File: rtl/sparce_skip_ctrl_if.sv
// Skip-request / fetch-redirect bundle between the sparsity logic, fetch stage and skip controller.
interface sparce_internal_if #(
    parameter int unsigned SKIP_W = 4,
    parameter int unsigned CNT_W  = 16
);
    logic              skip_req;
    logic [31:0]       skip_pc;
    logic [SKIP_W-1:0] skip_insts;
    logic              fetch_valid;
    logic              ctrl_flow_enable;
    logic              flush;
    logic              skip_ack;
    logic              skip_valid;
    logic [31:0]       skip_target;
    logic              busy;
    logic [CNT_W-1:0]  abort_cnt;

    modport skip_ctrl (
        input  skip_req, skip_pc, skip_insts, fetch_valid, ctrl_flow_enable, flush, skip_ack,
        output skip_valid, skip_target, busy, abort_cnt
    );

    modport slave (
        input  skip_req, skip_pc, skip_insts, fetch_valid, ctrl_flow_enable, flush, skip_ack,
        output skip_valid, skip_target, busy, abort_cnt
    );

    modport master (
        output skip_req, skip_pc, skip_insts, fetch_valid, ctrl_flow_enable, flush, skip_ack,
        input  skip_valid, skip_target, busy, abort_cnt
    );
endinterface

// File: rtl/sparce_skip_ctrl_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
module sparce_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/sparce_skip_ctrl.sv
// SparCE skip controller: verifies a candidate skip window is free of control flow,
// then issues a PC redirect to fetch with a valid/ack handshake.
module sparce_skip_ctrl
    import sparce_pkg::*;
#(
    parameter int unsigned SKIP_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    sparce_internal_if.skip_ctrl  io_skip
);
    sparce_skip_state_t r_state, w_state_next;
    logic [SKIP_W-1:0]  r_remain, w_remain_next;
    logic [31:0]        r_target, w_target_next;
    logic [31:0]        w_req_target;
    logic               r_valid;
    logic               r_busy;
    logic               w_abort;

    // Low PC bits are forced to zero; the window spans skip_insts words past skip_pc.
    assign w_req_target = {io_skip.skip_pc[31:2], 2'b00}
                        + ((32'(io_skip.skip_insts) + 32'd1) * SPARCE_INST_BYTES);

    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        w_target_next = r_target;
        w_abort       = 1'b0;
        if (io_skip.flush) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (io_skip.skip_req && (io_skip.skip_insts != '0)) begin
                        w_state_next  = SCAN;
                        w_remain_next = io_skip.skip_insts;
                        w_target_next = w_req_target;
                    end
                end
                SCAN: begin
                    if (io_skip.fetch_valid) begin
                        if (!io_skip.ctrl_flow_enable) begin
                            w_state_next = IDLE;
                            w_abort      = 1'b1;
                        end else begin
                            w_remain_next = r_remain - SKIP_W'(1);
                            if (r_remain == SKIP_W'(1)) begin
                                w_state_next = REDIRECT;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (io_skip.skip_ack) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so no input reaches an output directly.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_target <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_remain <= w_remain_next;
            r_target <= w_target_next;
            r_valid  <= (w_state_next == REDIRECT);
            r_busy   <= (w_state_next != IDLE);
        end
    end

    sparce_sat_counter #(
        .WIDTH (CNT_W)
    ) u_abort_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_inc   (w_abort),
        .o_count (io_skip.abort_cnt)
    );

    assign io_skip.skip_valid  = r_valid;
    assign io_skip.skip_target = r_target;
    assign io_skip.busy        = r_busy;
endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Bench for sparce_skip_ctrl: directed scenarios then random traffic against a window-level model;
// a second instance with a 2-bit abort counter exercises saturation.
module tb_sparce_skip_ctrl;
    logic CLK;
    logic nRST;

    sparce_internal_if #(.SKIP_W(4), .CNT_W(16)) bus ();
    sparce_internal_if #(.SKIP_W(4), .CNT_W(2))  bus2 ();

    sparce_skip_ctrl #(.SKIP_W(4), .CNT_W(16)) u_dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .io_skip (bus)
    );

    sparce_skip_ctrl #(.SKIP_W(4), .CNT_W(2)) u_dut_sat (
        .CLK     (CLK),
        .nRST    (nRST),
        .io_skip (bus2)
    );

    assign bus2.skip_req         = bus.skip_req;
    assign bus2.skip_pc          = bus.skip_pc;
    assign bus2.skip_insts       = bus.skip_insts;
    assign bus2.fetch_valid      = bus.fetch_valid;
    assign bus2.ctrl_flow_enable = bus.ctrl_flow_enable;
    assign bus2.flush            = bus.flush;
    assign bus2.skip_ack         = bus.skip_ack;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Window-level model: an open window either still needs m_left clean fetches or,
    // once m_left reaches zero, is waiting for fetch to take the redirect.
    bit          m_open;
    int          m_left;
    logic [31:0] m_target;
    int          m_aborts;

    function automatic void model_reset();
        m_open   = 1'b0;
        m_left   = 0;
        m_target = 32'h0;
        m_aborts = 0;
    endfunction

    function automatic void model_step();
        if (bus.flush) begin
            m_open = 1'b0;
        end else if (!m_open) begin
            if (bus.skip_req && bus.skip_insts != 0) begin
                m_open   = 1'b1;
                m_left   = int'(bus.skip_insts);
                m_target = (bus.skip_pc & 32'hFFFF_FFFC) + 32'(4 * (int'(bus.skip_insts) + 1));
            end
        end else if (m_left > 0) begin
            if (bus.fetch_valid) begin
                if (!bus.ctrl_flow_enable) begin
                    m_open   = 1'b0;
                    m_aborts = m_aborts + 1;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else if (bus.skip_ack) begin
            m_open = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sat16;
        int sat2;
        sat16 = (m_aborts > 65535) ? 65535 : m_aborts;
        sat2  = (m_aborts > 3) ? 3 : m_aborts;
        chk({tag, ".valid"},  32'(bus.skip_valid), 32'(m_open && m_left == 0));
        chk({tag, ".busy"},   32'(bus.busy), 32'(m_open));
        chk({tag, ".target"}, bus.skip_target, m_target);
        chk({tag, ".aborts"}, 32'(bus.abort_cnt), 32'(sat16));
        chk({tag, ".sat"},    32'(bus2.abort_cnt), 32'(sat2));
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic [3:0] n,
                         input logic fv, input logic cfe, input logic fl, input logic ack);
        bus.skip_req         = req;
        bus.skip_pc          = pc;
        bus.skip_insts       = n;
        bus.fetch_valid      = fv;
        bus.ctrl_flow_enable = cfe;
        bus.flush            = fl;
        bus.skip_ack         = ack;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic idle_cycle(input string tag);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(tag);
    endtask

    task automatic fetch(input logic cfe, input string tag);
        drive(1'b0, 32'h0, 4'd0, 1'b1, cfe, 1'b0, 1'b0);
        cycle(tag);
    endtask

    initial begin
        model_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        check_all("reset");
        nRST = 1'b1;
        idle_cycle("post_reset");

        // Clean window; the same-cycle fetch with the request must not count.
        drive(1'b1, 32'h100, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("clean_req");
        fetch(1'b1, "clean_f1");
        fetch(1'b1, "clean_f2");
        chk("clean_not_yet", 32'(bus.skip_valid), 32'd0);
        fetch(1'b1, "clean_f3");
        chk("clean_target", bus.skip_target, 32'h110);
        chk("clean_valid", 32'(bus.skip_valid), 32'd1);
        idle_cycle("clean_hold");
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("clean_ack");
        chk("clean_idle", 32'(bus.busy), 32'd0);

        // Abort on control flow at the second fetch.
        drive(1'b1, 32'h200, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("abort_req");
        fetch(1'b1, "abort_f1");
        fetch(1'b0, "abort_f2");
        chk("abort_count", 32'(bus.abort_cnt), 32'd1);

        // Fetch bubbles hold the window; ack while not valid is ignored.
        drive(1'b1, 32'h300, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("bub_req");
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("bub_gap_ack");
        fetch(1'b1, "bub_f1");
        idle_cycle("bub_gap2");
        idle_cycle("bub_gap3");
        fetch(1'b1, "bub_f2");
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("bub_ack");

        // Zero-length request is ignored.
        drive(1'b1, 32'h400, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("zero_req");
        chk("zero_busy", 32'(bus.busy), 32'd0);

        // Flush during scan, then flush together with ack in redirect.
        drive(1'b1, 32'h500, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("fl_req");
        fetch(1'b1, "fl_f1");
        drive(1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("fl_scan");
        drive(1'b1, 32'h600, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("fla_req");
        fetch(1'b1, "fla_f1");
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle("fla_both");

        // Request during scan is dropped; original target kept.
        drive(1'b1, 32'h700, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("drop_req");
        drive(1'b1, 32'h800, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("drop_req2");
        fetch(1'b1, "drop_f2");
        chk("drop_target", bus.skip_target, 32'h70C);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("drop_ack");

        // Wrap past the top of the address space, and low PC bits forced to zero.
        drive(1'b1, 32'hFFFF_FFF8, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("wrap_req");
        chk("wrap_target", bus.skip_target, 32'h0000_0004);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("wrap_flush");
        drive(1'b1, 32'h0000_0103, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("align_req");
        chk("align_target", bus.skip_target, 32'h108);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("align_flush");

        // Five more aborts push the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
            cycle("sat_req");
            fetch(1'b0, "sat_abort");
        end
        chk("sat_value", 32'(bus2.abort_cnt), 32'd3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) == 0), $urandom, 4'($urandom_range(15)),
                  1'($urandom_range(1)), ($urandom_range(7) != 0),
                  ($urandom_range(24) == 0), 1'($urandom_range(1)));
            cycle("rand");
        end

        // Asynchronous reset in the middle of a pending redirect.
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("pre_rst_flush");
        drive(1'b1, 32'h2000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("rst_req");
        fetch(1'b1, "rst_f1");
        chk("rst_in_redirect", 32'(bus.skip_valid), 32'd1);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge CLK);
        nRST = 1'b1;
        idle_cycle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
